// File: rtl/vga_timing_if.sv
// Raster timing bundle from the timing generator to renderers and the VGA connector.
interface vga_timing_if;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        blank;
    logic        hs;
    logic        vs;
    logic        frame_start;
    logic [15:0] frame_count;

    modport master (output DrawX, DrawY, blank, hs, vs, frame_start, frame_count);
    modport slave  (input  DrawX, DrawY, blank, hs, vs, frame_start, frame_count);
endinterface

// File: rtl/vga_timing_gen.sv
// Pixel-rate 640x480@60 raster generator: DrawX/DrawY/blank plus hs/vs delayed
// by SYNC_DELAY cycles so sync stays aligned with the registered renderer colour.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_DELAY = 1
) (
    input  logic        vga_clk,
    input  logic        reset,
    vga_timing_if.master vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [9:0]  hcnt, vcnt, h_nxt, v_nxt;
    logic        h_last, v_last;
    logic        hs_raw, vs_raw;
    logic [9:0]  draw_x, draw_y;
    logic        blank_q, frame_start_q, running;
    logic [15:0] frame_cnt;
    // Stage 0 is aligned with DrawX/DrawY; bit 1 = hs, bit 0 = vs.
    logic [SYNC_DELAY:0][1:0] sync_pipe;

    // All outputs decode the next-state counts so they land with the same pixel.
    always_comb begin
        h_last = (hcnt == H_LAST);
        v_last = (vcnt == V_LAST);
        h_nxt  = h_last ? 10'd0 : hcnt + 10'd1;
        v_nxt  = vcnt;
        if (h_last)
            v_nxt = v_last ? 10'd0 : vcnt + 10'd1;
        hs_raw = !((h_nxt >= HS_BEG) && (h_nxt < HS_END));
        vs_raw = !((v_nxt >= VS_BEG) && (v_nxt < VS_END));
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hcnt          <= H_LAST;
            vcnt          <= V_LAST;
            draw_x        <= '0;
            draw_y        <= '0;
            blank_q       <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt     <= '0;
            running       <= 1'b0;
            sync_pipe     <= '1;
        end else begin
            hcnt          <= h_nxt;
            vcnt          <= v_nxt;
            draw_x        <= h_nxt;
            draw_y        <= v_nxt;
            blank_q       <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
            frame_start_q <= (h_nxt == 10'd0) && (v_nxt == 10'd0);
            running       <= 1'b1;
            // The parked post-reset position wraps to (0,0) without completing a frame.
            if (h_last && v_last && running)
                frame_cnt <= frame_cnt + 16'd1;
            sync_pipe[0] <= {hs_raw, vs_raw};
            for (int i = 1; i <= SYNC_DELAY; i++)
                sync_pipe[i] <= sync_pipe[i-1];
        end
    end

    assign vga.DrawX       = draw_x;
    assign vga.DrawY       = draw_y;
    assign vga.blank       = blank_q;
    assign vga.frame_start = frame_start_q;
    assign vga.frame_count = frame_cnt;
    assign vga.hs          = sync_pipe[SYNC_DELAY][1];
    assign vga.vs          = sync_pipe[SYNC_DELAY][0];
endmodule
